// File: rtl/fpu_pkg.sv
// Shared FPU types and helpers used by the issue stages in front of the
// floating-point cores.
package fpu_pkg;

   typedef struct packed {
      logic       sign;
      logic [7:0] exp;
      logic [22:0] man;
   } fp32_t;

   typedef enum logic {
      FOP_ADD = 1'b0,
      FOP_SUB = 1'b1
   } fop_e;

   localparam logic [7:0] EXP_ZERO = 8'h00;
   localparam logic [7:0] EXP_MAX  = 8'hFF;

   // Zeros/subnormals collapse to signed zero and Inf/NaN collapse to signed
   // infinity, so the cores never see a special mantissa.
   function automatic fp32_t flush_special(input fp32_t x);
      fp32_t r;
      r = x;
      if ((x.exp == EXP_ZERO) || (x.exp == EXP_MAX)) begin
         r.man = '0;
      end
      return r;
   endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Small synchronous FIFO holding finished FPU results until the consumer
// takes them. The head entry is presented combinationally and reads as zero
// while the FIFO is empty.
module fpu_result_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             full;
   logic             do_pop;

   assign empty  = (count_q == '0);
   assign full   = (count_q == (PTR_W+1)'(DEPTH));
   assign count  = count_q;
   assign do_pop = pop && !empty;

   // Pointer and occupancy update; a simultaneous push and pop keeps the count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !do_pop) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (!push && do_pop) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = empty ? '0 : mem[rd_ptr_q];

   // The upstream credit scheme must never let a result arrive into a full FIFO.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rstn) !(push && full));

endmodule

// File: rtl/fadd_issue.sv
// Issue/collect stage around the fadd core: flushes special operands,
// registers them into fadd, tracks operations in flight for the fixed fadd
// latency and buffers results in order behind a credit-based input port.
module fadd_issue
   import fpu_pkg::*;
#(
   parameter int FADD_LAT   = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      fa_x1,
   output logic [31:0]      fa_x2,
   input  logic [31:0]      fa_y,
   input  logic             fa_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_y,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TRK_N = FADD_LAT + 1;
   localparam int ENT_W = 32 + 1 + TAG_W;

   logic             accept;
   fp32_t            a_flush;
   fp32_t            b_flush;
   logic [31:0]      x1_q, x1_d;
   logic [31:0]      x2_q, x2_d;

   logic [TRK_N-1:0] trk_vld_q, trk_vld_d;
   logic [TAG_W-1:0] trk_tag_q [TRK_N];
   logic [TAG_W-1:0] trk_tag_d [TRK_N];
   int               inflight_cnt;

   logic             capture;
   logic             pop;
   logic [ENT_W-1:0] push_data;
   logic [ENT_W-1:0] head_data;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   assign accept = in_valid && in_ready;

   // Operand flush and subtract-by-negation, loaded into fadd only on accept.
   always_comb begin
      a_flush = flush_special(in_a);
      b_flush = flush_special(in_b);
      if (in_op == FOP_SUB) begin
         b_flush.sign = ~b_flush.sign;
      end
      x1_d = x1_q;
      x2_d = x2_q;
      if (accept) begin
         x1_d = a_flush;
         x2_d = b_flush;
      end
   end

   // fadd operand registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         x1_q <= '0;
         x2_q <= '0;
      end else begin
         x1_q <= x1_d;
         x2_q <= x2_d;
      end
   end

   assign fa_x1 = x1_q;
   assign fa_x2 = x2_q;

   // In-flight tracker: stage 0 holds the op issued at the last edge; the
   // last stage lines up with fadd's result for that op. Never stalls.
   for (genvar gi = 0; gi < TRK_N; gi++) begin : g_trk
      if (gi == 0) begin : g_head
         assign trk_vld_d[gi] = accept;
         assign trk_tag_d[gi] = in_tag;
      end else begin : g_body
         assign trk_vld_d[gi] = trk_vld_q[gi-1];
         assign trk_tag_d[gi] = trk_tag_q[gi-1];
      end
   end

   // Tracker shift register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         trk_vld_q <= '0;
         for (int i = 0; i < TRK_N; i++) begin
            trk_tag_q[i] <= '0;
         end
      end else begin
         trk_vld_q <= trk_vld_d;
         for (int i = 0; i < TRK_N; i++) begin
            trk_tag_q[i] <= trk_tag_d[i];
         end
      end
   end

   // Credits: every op accepted but not yet popped holds one FIFO slot. Both
   // counts come from registers, so in_ready has no path from in_valid/out_ready.
   always_comb begin
      inflight_cnt = 0;
      for (int i = 0; i < TRK_N; i++) begin
         inflight_cnt = inflight_cnt + int'(trk_vld_q[i]);
      end
   end

   assign in_ready = (int'(fifo_count) + inflight_cnt) < FIFO_DEPTH;

   assign capture   = trk_vld_q[TRK_N-1];
   assign push_data = {fa_y, fa_ovf, trk_tag_q[TRK_N-1]};
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;

   fpu_result_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_result_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (capture),
      .pop   (pop),
      .wdata (push_data),
      .rdata (head_data),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign {out_y, out_ovf, out_tag} = head_data;
   assign busy = (|trk_vld_q) || (fifo_count != '0);

endmodule
